// File: rtl/mod_fifo_pkg.sv
// Shared defaults and pointer-width helper for the mod_fifo slice.
package mod_fifo_pkg;

  localparam int DWIDTH_DEF = 8;
  localparam int DEPTH_DEF  = 4;

  // One extra MSB beyond the index distinguishes full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mod_fifo_mem.sv
// DEPTH x DWIDTH storage: synchronous write port, asynchronous read port.
module mod_fifo_mem #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mod_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers.
// Optional occupancy output enabled by defining MOD_FIFO_COUNT_EN.
module mod_fifo
  import mod_fifo_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DWIDTH-1:0]         data_in,
  input  logic                      wr_en,
  output logic                      full,
  input  logic                      rd_en,
  output logic [DWIDTH-1:0]         data_out,
`ifdef MOD_FIFO_COUNT_EN
  output logic                      empty,
  output logic [ptr_w(DEPTH)-1:0]   count
`else
  output logic                      empty
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              wr_acc, rd_acc;
  logic [DWIDTH-1:0] head_data;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  // The full/empty gating alone resolves simultaneous requests at the boundaries.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef MOD_FIFO_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
`endif

  mod_fifo_mem #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk    (clk),
    .we     (wr_acc && rst_n),
    .waddr  (wr_ptr[AW-1:0]),
    .wdata  (data_in),
    .raddr  (rd_ptr[AW-1:0]),
    .rdata  (head_data)
  );

  assign data_out = empty ? '0 : head_data;

endmodule

// File: tb/tb_mod_fifo.sv
// Bench for mod_fifo: directed scenarios then random traffic against a queue model.
module tb_mod_fifo;

  localparam int DW = 8;
  localparam int DP = 4;
  localparam int PW = $clog2(DP) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          full, empty;
`ifdef MOD_FIFO_COUNT_EN
  logic [PW-1:0] count;
`endif

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] q[$];

  always #5 clk = ~clk;

  mod_fifo #(.DWIDTH(DW), .DEPTH(DP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .wr_en    (wr_en),
    .full     (full),
    .rd_en    (rd_en),
    .data_out (data_out),
`ifdef MOD_FIFO_COUNT_EN
    .empty    (empty),
    .count    (count)
`else
    .empty    (empty)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, update model with the pre-edge occupancy, compare after the edge.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic rn);
    bit m_full, m_empty;
    data_in = d;
    wr_en   = w;
    rd_en   = r;
    rst_n   = rn;
    @(posedge clk);
    if (!rn) begin
      q.delete();
    end else begin
      m_full  = (q.size() == DP);
      m_empty = (q.size() == 0);
      if (r && !m_empty) void'(q.pop_front());
      if (w && !m_full) q.push_back(d);
    end
    #1;
    chk("empty", {31'b0, empty}, {31'b0, q.size() == 0});
    chk("full", {31'b0, full}, {31'b0, q.size() == DP});
    chk("data_out", {24'b0, data_out}, (q.size() != 0) ? {24'b0, q[0]} : 32'h0);
`ifdef MOD_FIFO_COUNT_EN
    chk("count", {{(32-PW){1'b0}}, count}, q.size());
`endif
  endtask

  initial begin
    logic [DW-1:0] e29 [4];
    e29[0] = 8'hA1; e29[1] = 8'hB2; e29[2] = 8'hC3; e29[3] = 8'hD4;

    // Reset then idle
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("idle_empty", {31'b0, empty}, 32'h1);
    chk("idle_full", {31'b0, full}, 32'h0);
    chk("idle_dout", {24'b0, data_out}, 32'h00);
`ifdef MOD_FIFO_COUNT_EN
    chk("idle_count", {{(32-PW){1'b0}}, count}, 32'h0);
`endif

    // Fill, overflow drop, drain in order
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, e29[i], 1'b1);
    chk("fill_full", {31'b0, full}, 32'h1);
    step(1'b1, 1'b0, 8'hEE, 1'b1);
    chk("ovf_full", {31'b0, full}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_head", {24'b0, data_out}, {24'b0, e29[i]});
      step(1'b0, 1'b1, 8'h00, 1'b1);
    end
    chk("drain_empty", {31'b0, empty}, 32'h1);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    chk("udf_empty", {31'b0, empty}, 32'h1);

    // Simultaneous read/write at occupancy 2
    step(1'b1, 1'b0, 8'h11, 1'b1);
    step(1'b1, 1'b0, 8'h22, 1'b1);
    step(1'b1, 1'b1, 8'h33, 1'b1);
    chk("rw2_head", {24'b0, data_out}, 32'h22);
    step(1'b1, 1'b1, 8'h44, 1'b1);
    chk("rw2_head2", {24'b0, data_out}, 32'h33);
`ifdef MOD_FIFO_COUNT_EN
    chk("rw2_count", {{(32-PW){1'b0}}, count}, 32'h2);
`endif
    step(1'b0, 1'b1, 8'h00, 1'b1);
    chk("rw2_tail", {24'b0, data_out}, 32'h44);
    step(1'b0, 1'b1, 8'h00, 1'b1);

    // Full with both requests: read wins
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, DW'(i), 1'b1);
    step(1'b1, 1'b1, 8'h99, 1'b1);
    chk("fullrw_full", {31'b0, full}, 32'h0);
    chk("fullrw_head", {24'b0, data_out}, 32'h02);
`ifdef MOD_FIFO_COUNT_EN
    chk("fullrw_count", {{(32-PW){1'b0}}, count}, 32'h3);
`endif
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, 1'b1);

    // Empty with both requests: write wins
    step(1'b1, 1'b1, 8'h5A, 1'b1);
    chk("emptyrw_dout", {24'b0, data_out}, 32'h5A);
    chk("emptyrw_empty", {31'b0, empty}, 32'h0);
    step(1'b0, 1'b1, 8'h00, 1'b1);

    // Reset mid-operation with a write pending
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'hC0 + DW'(i), 1'b1);
    step(1'b1, 1'b0, 8'h88, 1'b0);
    chk("midrst_empty", {31'b0, empty}, 32'h1);
`ifdef MOD_FIFO_COUNT_EN
    chk("midrst_count", {{(32-PW){1'b0}}, count}, 32'h0);
`endif
    step(1'b1, 1'b0, 8'h77, 1'b1);
    chk("postrst_dout", {24'b0, data_out}, 32'h77);
    step(1'b0, 1'b1, 8'h00, 1'b1);

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           DW'($urandom), ($urandom_range(0, 31) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_fifo.md
MOD_FIFO -- requirements
Module: mod_fifo

Interface
REQ-001 SHALL have parameter DWIDTH, int, default 8: data width in bits, equal to the INTPARAM1 of the consuming stage.
REQ-002 SHALL have parameter DEPTH, int, default 4: number of entries, a power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low; the block has one clock.
REQ-005 SHALL have port data_in, input, DWIDTH bits: write data.
REQ-006 SHALL have port wr_en, input, 1 bit: write request.
REQ-007 SHALL have port full, output, 1 bit: no free entry.
REQ-008 SHALL have port rd_en, input, 1 bit: read request (pop).
REQ-009 SHALL have port data_out, output, DWIDTH bits: head entry; feeds the consumer's data_in.
REQ-010 SHALL have port empty, output, 1 bit: no valid entry.

Function
REQ-011 SHALL accept a write only when wr_en=1 and full=0, storing data_in at the tail on that edge.
REQ-012 SHALL accept a read only when rd_en=1 and empty=0, advancing the head on that edge.
REQ-013 SHALL be first-word-fall-through: data_out = head entry whenever empty=0, and '0 whenever empty=1.
REQ-014 SHALL have write-to-output latency of 1 cycle: data written at edge N appears on data_out and empty=0 after edge N.
REQ-015 SHALL keep pointers of $clog2(DEPTH)+1 bits, wrapping modulo 2*DEPTH.
REQ-016 SHALL derive empty and full from pointer equality: empty when the pointers are equal; full when the indices are equal and the MSBs differ.
REQ-017 SHALL complete both operations on the same edge when a write and a read arrive together with 0<occupancy<DEPTH, leaving occupancy unchanged.
REQ-018 SHALL, when full and wr_en=rd_en=1, accept the read and ignore the write.
REQ-019 SHALL, when empty and wr_en=rd_en=1, accept the write and ignore the read.
REQ-020 SHALL treat a write while full (overflow) and a read while empty (underflow) as no-ops, leaving storage and pointers unchanged.

Reset
REQ-021 SHALL, on a clk edge with rst_n=0, clear both pointers, giving empty=1, full=0 and data_out='0 after that edge.
REQ-022 SHALL not clear storage on reset; stale entries are unreachable.
REQ-023 SHALL, when reset is asserted mid-operation, discard all entries and ignore wr_en and rd_en on that edge.

Configuration
REQ-024 SHALL, with MOD_FIFO_COUNT_EN defined, add output count, $clog2(DEPTH)+1 bits, equal to the occupancy, registered, updated on the same edge as the pointers, and reset to 0.
REQ-025 SHALL, without MOD_FIFO_COUNT_EN, have no count port and no count logic.

Structure
REQ-026 SHALL place DWIDTH_DEF=8, DEPTH_DEF=4 and a pointer-width function in package mod_fifo_pkg.
REQ-027 SHALL use a single sub-module, mod_fifo_mem: a DEPTH x DWIDTH array with a synchronous write port and an asynchronous read port.

Verification
REQ-028 SHALL cover reset then idle: empty=1, full=0, data_out=8'h00, count=0.
REQ-029 SHALL cover writing 8'hA1, 8'hB2, 8'hC3, 8'hD4, which gives full=1; a further write of 8'hEE is dropped; four reads return A1, B2, C3, D4, then empty=1.
REQ-030 SHALL cover simultaneous read and write at occupancy 2: occupancy stays 2 and data order is preserved.
REQ-031 SHALL cover full with wr_en=rd_en=1: head popped, write ignored, full=0, count=3.
REQ-032 SHALL cover empty with wr_en=rd_en=1 and data 8'h5A: data_out=8'h5A next cycle, empty=0.
REQ-033 SHALL cover rst_n=0 at occupancy 3 together with wr_en=1: empty=1 and count=0 after the edge, and a first write of 8'h77 after reset is read back as 8'h77.
